// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: answers PC fetch requests via a sync-read memory and a 2-entry response queue.
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_CHECK_EN.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif
module instr_fetch_responder #(
`ifdef CUSTOM_DEFINE
    parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH,
`else
    parameter int MEM_ADDR_WIDTH = 10,
`endif
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid_i,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr_i,
    output logic                      req_ready_o,
    input  logic                      flush_i,
    output logic                      mem_rd_o,
    output logic [MEM_ADDR_WIDTH-3:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_instr_o,
    output logic [MEM_ADDR_WIDTH-1:0] rsp_addr_o,
    output logic                      rsp_err_o
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

    logic [1:0]                count;
    logic                      wptr, rptr, inflight, inf_err;
    logic [MEM_ADDR_WIDTH-1:0] inf_addr;
    logic [DATA_WIDTH-1:0]     q_instr [2];
    logic [MEM_ADDR_WIDTH-1:0] q_addr [2];
    logic [1:0]                q_err;
    logic                      accept, pop, misalign;
    logic [2:0]                occ;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = req_addr_i[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif

    // A slot is reserved for every in-flight read, so the queue can never overflow.
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign occ         = {1'b0, count} + {2'b00, inflight};
    assign req_ready_o = rst_n && !flush_i && (occ < 3'd2 + {2'b00, pop});
    assign accept      = req_valid_i && req_ready_o;
    assign mem_rd_o    = accept && !misalign;
    assign mem_addr_o  = req_addr_i[MEM_ADDR_WIDTH-1:2];
    assign rsp_valid_o = count != 2'd0;
    assign rsp_instr_o = q_instr[rptr];
    assign rsp_addr_o  = q_addr[rptr];
    assign rsp_err_o   = q_err[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            inflight <= 1'b0;
            inf_err  <= 1'b0;
            inf_addr <= '0;
            q_instr  <= '{default: '0};
            q_addr   <= '{default: '0};
            q_err    <= '0;
        end else if (flush_i) begin
            count    <= '0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inf_addr <= req_addr_i;
                inf_err  <= misalign;
            end
            if (inflight) begin
                q_instr[wptr] <= inf_err ? NOP : mem_rdata_i;
                q_addr[wptr]  <= inf_addr;
                q_err[wptr]   <= inf_err;
                wptr          <= !wptr;
            end
            if (pop)
                rptr <= !rptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule
